// File: rtl/ex_if.sv
// ex_if: execute-stage bundle (decode input, memory/forwarding/hilo/SRAM outputs).
// slave = execute stage, master = surrounding pipeline.
interface ex_if #(
   parameter int ID_TO_EX_WD  = 162,
   parameter int EX_TO_MEM_WD = 73
);
   logic [5:0]              stall;
   logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic                    ex_rf_we;
   logic [4:0]              ex_rf_waddr;
   logic [31:0]             ex_ex_result;
   logic                    is_lw;
   logic [65:0]             ex_hilo;
   logic                    data_sram_en;
   logic [3:0]              data_sram_wen;
   logic [31:0]             data_sram_addr;
   logic [31:0]             data_sram_wdata;
   logic                    stallreq_for_ex;

   modport slave (
      input  stall, id_to_ex_bus,
      output ex_to_mem_bus, ex_rf_we, ex_rf_waddr, ex_ex_result,
      output is_lw, ex_hilo, data_sram_en, data_sram_wen,
      output data_sram_addr, data_sram_wdata, stallreq_for_ex
   );

   modport master (
      output stall, id_to_ex_bus,
      input  ex_to_mem_bus, ex_rf_we, ex_rf_waddr, ex_ex_result,
      input  is_lw, ex_hilo, data_sram_en, data_sram_wen,
      input  data_sram_addr, data_sram_wdata, stallreq_for_ex
   );
endinterface

// File: rtl/ex.sv
// ex: execute stage -- ALU, 1-cycle multiply, mthi/mtlo, 32-cycle restoring divider.
// Ports: clk, rst (sync, active high), bus (ex_if.slave: stall/id_to_ex_bus in, rest out).
module ex #(
   parameter int ID_TO_EX_WD  = 162,
   parameter int EX_TO_MEM_WD = 73
) (
   input logic clk,
   input logic rst,
   ex_if.slave bus
);
   typedef struct packed {
      logic        div;
      logic        divu;
      logic        mult;
      logic        multu;
      logic        mthi;
      logic        mtlo;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [11:0] alu_op;
      logic [2:0]  sel_src1;
      logic [3:0]  sel_src2;
      logic        ram_en;
      logic        ram_wen;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic        sel_rf_res;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
   } id_ex_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_st_t;

   logic [ID_TO_EX_WD-1:0] pipe_q;
   id_ex_t                 r;
   logic [31:0]            src1;
   logic [31:0]            src2;
   logic [31:0]            alu_res;
   logic [4:0]             sh;
   logic signed [63:0]     prod_s;
   logic [63:0]            prod_u;
   logic [65:0]            hilo;

   div_st_t     st;
   logic [4:0]  cnt;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic        neg_q;
   logic        neg_r;
   logic        dz_q;
   logic        div_op;
   logic [31:0] abs_rs;
   logic [31:0] abs_rt;
   logic [32:0] trial;
   logic        fit;
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic        unused_ok;

   assign r = id_ex_t'(pipe_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_q <= '0;
      end else if (bus.stall[2] && !bus.stall[3]) begin
         pipe_q <= '0;
      end else if (!bus.stall[2]) begin
         pipe_q <= bus.id_to_ex_bus;
      end
   end

   always_comb begin
      src1 = '0;
      unique case (1'b1)
         r.sel_src1[0]: src1 = r.rs_val;
         r.sel_src1[1]: src1 = r.pc;
         r.sel_src1[2]: src1 = {27'b0, r.inst[10:6]};
         default:       src1 = '0;
      endcase
   end

   always_comb begin
      src2 = '0;
      unique case (1'b1)
         r.sel_src2[0]: src2 = r.rt_val;
         r.sel_src2[1]: src2 = {{16{r.inst[15]}}, r.inst[15:0]};
         r.sel_src2[2]: src2 = 32'd8;
         r.sel_src2[3]: src2 = {16'b0, r.inst[15:0]};
         default:       src2 = '0;
      endcase
   end

   assign sh = src1[4:0];

   always_comb begin
      alu_res = '0;
      unique case (1'b1)
         r.alu_op[11]: alu_res = src1 + src2;
         r.alu_op[10]: alu_res = src1 - src2;
         r.alu_op[9]:  alu_res = {31'b0, $signed(src1) < $signed(src2)};
         r.alu_op[8]:  alu_res = {31'b0, src1 < src2};
         r.alu_op[7]:  alu_res = src1 & src2;
         r.alu_op[6]:  alu_res = ~(src1 | src2);
         r.alu_op[5]:  alu_res = src1 | src2;
         r.alu_op[4]:  alu_res = src1 ^ src2;
         r.alu_op[3]:  alu_res = src2 << sh;
         r.alu_op[2]:  alu_res = src2 >> sh;
         r.alu_op[1]:  alu_res = $signed(src2) >>> sh;
         r.alu_op[0]:  alu_res = {src2[15:0], 16'b0};
         default:      alu_res = '0;
      endcase
   end

   assign prod_s = $signed({{32{r.rs_val[31]}}, r.rs_val})
                 * $signed({{32{r.rt_val[31]}}, r.rt_val});
   assign prod_u = {32'b0, r.rs_val} * {32'b0, r.rt_val};

   // Divider works on magnitudes; signs are re-applied when presenting.
   assign div_op = r.div | r.divu;
   assign abs_rs = (r.div && r.rs_val[31]) ? -r.rs_val : r.rs_val;
   assign abs_rt = (r.div && r.rt_val[31]) ? -r.rt_val : r.rt_val;
   assign trial  = {rem_q, quo_q[31]};
   assign fit    = trial >= {1'b0, dvs_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= IDLE;
         cnt   <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz_q  <= 1'b0;
      end else begin
         unique case (st)
            IDLE: begin
               if (div_op) begin
                  rem_q <= '0;
                  quo_q <= abs_rs;
                  dvs_q <= abs_rt;
                  cnt   <= '0;
                  neg_q <= r.div & (r.rs_val[31] ^ r.rt_val[31]);
                  neg_r <= r.div & r.rs_val[31];
                  dz_q  <= r.rt_val == '0;
                  st    <= BUSY;
               end
            end
            BUSY: begin
               // quo_q doubles as the dividend shift register
               rem_q <= fit ? trial[31:0] - dvs_q : trial[31:0];
               quo_q <= {quo_q[30:0], fit};
               cnt   <= cnt + 5'd1;
               if (cnt == 5'd31) st <= DONE;
            end
            DONE: st <= IDLE;
            default: st <= IDLE;
         endcase
      end
   end

   // Zero divisor leaves |dividend| as remainder; only the quotient is forced.
   assign q_fix = dz_q ? 32'hFFFF_FFFF : (neg_q ? -quo_q : quo_q);
   assign r_fix = neg_r ? -rem_q : rem_q;

   always_comb begin
      hilo = '0;
      unique case (1'b1)
         st == DONE: hilo = {2'b11, r_fix, q_fix};
         r.mult:     hilo = {2'b11, prod_s};
         r.multu:    hilo = {2'b11, prod_u};
         r.mthi:     hilo = {2'b10, r.rs_val, 32'b0};
         r.mtlo:     hilo = {2'b01, 32'b0, r.rs_val};
         default:    hilo = '0;
      endcase
   end

   assign bus.ex_to_mem_bus = EX_TO_MEM_WD'({r.pc, r.ram_en, r.ram_wen,
                              r.sel_rf_res, r.rf_we, r.rf_waddr, alu_res});
   assign bus.ex_rf_we        = r.rf_we;
   assign bus.ex_rf_waddr     = r.rf_waddr;
   assign bus.ex_ex_result    = alu_res;
   assign bus.is_lw           = r.sel_rf_res;
   assign bus.ex_hilo         = hilo;
   assign bus.data_sram_en    = r.ram_en;
   assign bus.data_sram_wen   = {4{r.ram_wen}};
   assign bus.data_sram_addr  = alu_res;
   assign bus.data_sram_wdata = r.rt_val;
   assign bus.stallreq_for_ex = (st == IDLE && div_op) || st == BUSY;

   assign unused_ok = ^{bus.stall[5:4], bus.stall[1:0], r.inst[31:16]};
endmodule

// File: tb/tb_ex.sv
// tb_ex: random + directed stimulus for ex, checked each cycle against a
// behavioural model (arithmetic ALU/mul/div, divide timeline as a phase number).
module tb_ex;
   localparam int IW = 162;
   localparam int OW = 73;

   typedef struct packed {
      logic        div;
      logic        divu;
      logic        mult;
      logic        multu;
      logic        mthi;
      logic        mtlo;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [11:0] alu_op;
      logic [2:0]  sel_src1;
      logic [3:0]  sel_src2;
      logic        ram_en;
      logic        ram_wen;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic        sel_rf_res;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
   } ie_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ex_if #(.ID_TO_EX_WD(IW), .EX_TO_MEM_WD(OW)) bus ();
   ex #(.ID_TO_EX_WD(IW), .EX_TO_MEM_WD(OW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int  total = 0;
   int  bad = 0;
   bit  chk_en = 1'b0;
   ie_t m_reg = '0;
   int  m_ph = 0;  // 0 idle, 1..32 divider busy, 33 result cycle

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] e_alu(input ie_t t);
      logic [31:0] a, b;
      longint v;
      int n;
      a = 32'd0;
      b = 32'd0;
      if (t.sel_src1[0]) a = t.rs_val;
      else if (t.sel_src1[1]) a = t.pc;
      else if (t.sel_src1[2]) a = {27'd0, t.inst[10:6]};
      if (t.sel_src2[0]) b = t.rt_val;
      else if (t.sel_src2[1]) b = {{16{t.inst[15]}}, t.inst[15:0]};
      else if (t.sel_src2[2]) b = 32'd8;
      else if (t.sel_src2[3]) b = {16'd0, t.inst[15:0]};
      n = int'(a[4:0]);
      if (t.alu_op[11]) return a + b;
      if (t.alu_op[10]) return a - b;
      if (t.alu_op[9]) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (t.alu_op[8]) return (a < b) ? 32'd1 : 32'd0;
      if (t.alu_op[7]) return a & b;
      if (t.alu_op[6]) return ~(a | b);
      if (t.alu_op[5]) return a | b;
      if (t.alu_op[4]) return a ^ b;
      if (t.alu_op[3]) return b << n;
      if (t.alu_op[2]) return b >> n;
      if (t.alu_op[1]) begin
         v = longint'($signed(b));
         v = v >>> n;
         return v[31:0];
      end
      if (t.alu_op[0]) return {b[15:0], 16'd0};
      return 32'd0;
   endfunction

   function automatic logic [63:0] e_div(input ie_t t);
      longint a, b, q, r;
      if (t.rt_val == 32'd0) return {t.rs_val, 32'hFFFF_FFFF};
      if (t.div) begin
         a = longint'($signed(t.rs_val));
         b = longint'($signed(t.rt_val));
      end else begin
         a = longint'({32'd0, t.rs_val});
         b = longint'({32'd0, t.rt_val});
      end
      q = a / b;
      r = a % b;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [65:0] e_hilo(input ie_t t, input int ph);
      longint p;
      logic [63:0] up;
      if (ph == 33) return {2'b11, e_div(t)};
      if (t.mult) begin
         p = longint'($signed(t.rs_val)) * longint'($signed(t.rt_val));
         return {2'b11, p};
      end
      if (t.multu) begin
         up = {32'd0, t.rs_val} * {32'd0, t.rt_val};
         return {2'b11, up};
      end
      if (t.mthi) return {2'b10, t.rs_val, 32'd0};
      if (t.mtlo) return {2'b01, 32'd0, t.rs_val};
      return 66'd0;
   endfunction

   function automatic logic e_stall(input ie_t t, input int ph);
      return (ph == 0 && (t.div || t.divu)) || (ph >= 1 && ph <= 32);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_reg = '0;
         m_ph = 0;
      end else begin
         if (m_ph == 0) begin
            if (m_reg.div || m_reg.divu) m_ph = 1;
         end else if (m_ph == 33) begin
            m_ph = 0;
         end else begin
            m_ph = m_ph + 1;
         end
         if (bus.stall[2] && !bus.stall[3]) m_reg = '0;
         else if (!bus.stall[2]) m_reg = bus.id_to_ex_bus;
      end
   end

   always @(negedge clk) begin
      logic [31:0] er;
      if (chk_en) begin
         er = e_alu(m_reg);
         chk("mem_bus", 128'(bus.ex_to_mem_bus), 128'({m_reg.pc, m_reg.ram_en,
             m_reg.ram_wen, m_reg.sel_rf_res, m_reg.rf_we, m_reg.rf_waddr, er}));
         chk("rf_we", 128'(bus.ex_rf_we), 128'(m_reg.rf_we));
         chk("rf_waddr", 128'(bus.ex_rf_waddr), 128'(m_reg.rf_waddr));
         chk("ex_result", 128'(bus.ex_ex_result), 128'(er));
         chk("is_lw", 128'(bus.is_lw), 128'(m_reg.sel_rf_res));
         chk("hilo", 128'(bus.ex_hilo), 128'(e_hilo(m_reg, m_ph)));
         chk("sram_en", 128'(bus.data_sram_en), 128'(m_reg.ram_en));
         chk("sram_wen", 128'(bus.data_sram_wen), 128'({4{m_reg.ram_wen}}));
         chk("sram_addr", 128'(bus.data_sram_addr), 128'(er));
         chk("sram_wdata", 128'(bus.data_sram_wdata), 128'(m_reg.rt_val));
         chk("stallreq", 128'(bus.stallreq_for_ex), 128'(e_stall(m_reg, m_ph)));
      end
   end

   // Stall follows the divider like the real pipeline; extra stalls only
   // when no divide owns the stage.
   task automatic tick(input ie_t b, input logic [1:0] x, input logic r);
      logic [31:0] rnd;
      logic [1:0] s;
      logic sr;
      @(negedge clk);
      rnd = $urandom;
      sr = e_stall(m_reg, m_ph);
      if (m_reg.div || m_reg.divu || sr) s = {sr, sr};
      else s = x;
      bus.id_to_ex_bus = b;
      bus.stall = {rnd[3:2], s, rnd[1:0]};
      rst = r;
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h8000_0000;
         3: v = 32'd1;
         4: v = 32'($urandom_range(0, 20));
         5: v = -32'($urandom_range(1, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   function automatic ie_t rand_bus();
      ie_t t;
      int k;
      logic [31:0] f;
      t = '0;
      f = $urandom;
      t.pc = $urandom;
      t.inst = $urandom;
      t.ram_en = f[0];
      t.ram_wen = f[1];
      t.rf_we = f[2];
      t.rf_waddr = f[7:3];
      t.sel_rf_res = f[8];
      t.rs_val = pick();
      t.rt_val = pick();
      k = $urandom_range(0, 3);
      if (k < 3) t.sel_src1 = 3'b001 << k;
      k = $urandom_range(0, 4);
      if (k < 4) t.sel_src2 = 4'b0001 << k;
      k = $urandom_range(0, 19);
      if (k < 12) t.alu_op = 12'b1 << k;
      else if (k == 13) t.mult = 1'b1;
      else if (k == 14) t.multu = 1'b1;
      else if (k == 15) t.mthi = 1'b1;
      else if (k == 16) t.mtlo = 1'b1;
      else if (k == 17) t.div = 1'b1;
      else if (k == 18) t.divu = 1'b1;
      return t;
   endfunction

   task automatic run_div(input ie_t b, output int ns, output logic [65:0] hl,
                          output bit got);
      ns = 0;
      got = 1'b0;
      hl = '0;
      tick(b, 2'b00, 1'b0);
      for (int c = 0; c < 60 && !got; c++) begin
         @(posedge clk);
         #1;
         if (bus.stallreq_for_ex) ns++;
         if (bus.ex_hilo[65:64] == 2'b11) begin
            got = 1'b1;
            hl = bus.ex_hilo;
         end else begin
            tick('0, 2'b00, 1'b0);
         end
      end
      if (!got) chk("div_timeout", 128'(got), 128'h1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      ie_t t;
      int ns;
      logic [65:0] hl;
      bit got;
      logic [1:0] x;
      bus.stall = '0;
      bus.id_to_ex_bus = '0;

      t = '0;
      t.alu_op = 12'h800;
      t.sel_src1 = 3'b001;
      t.sel_src2 = 4'b0001;
      t.rs_val = 32'hFFFF_FFFF;
      t.rt_val = 32'd2;
      chk("pin_alu_add", 128'(e_alu(t)), 128'h1);
      t = '0;
      t.div = 1'b1;
      t.rs_val = -32'd7;
      t.rt_val = 32'd2;
      chk("pin_div", 128'(e_div(t)), 128'hFFFF_FFFF_FFFF_FFFD);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_bus", 128'(bus.ex_to_mem_bus), 128'h0);
      chk("rst_hilo", 128'(bus.ex_hilo), 128'h0);
      chk("rst_stallreq", 128'(bus.stallreq_for_ex), 128'h0);
      chk("rst_sram", 128'({bus.data_sram_en, bus.data_sram_wen,
          bus.data_sram_addr, bus.data_sram_wdata}), 128'h0);
      chk("rst_fwd", 128'({bus.ex_rf_we, bus.ex_rf_waddr, bus.ex_ex_result,
          bus.is_lw}), 128'h0);
      chk_en = 1'b1;

      t = '0;
      t.alu_op = 12'h800;
      t.sel_src1 = 3'b001;
      t.sel_src2 = 4'b0001;
      t.rf_we = 1'b1;
      t.rf_waddr = 5'd3;
      t.rs_val = 32'hFFFF_FFFF;
      t.rt_val = 32'd2;
      tick(t, 2'b00, 1'b0);
      @(posedge clk);
      #1;
      chk("addu_res", 128'(bus.ex_ex_result), 128'h1);
      chk("addu_we", 128'(bus.ex_rf_we), 128'h1);

      t = '0;
      t.alu_op = 12'h800;
      t.sel_src1 = 3'b001;
      t.sel_src2 = 4'b0010;
      t.inst = 32'hAC00_FFFC;
      t.ram_en = 1'b1;
      t.ram_wen = 1'b1;
      t.rs_val = 32'h0000_1000;
      t.rt_val = 32'hDEAD_BEEF;
      tick(t, 2'b00, 1'b0);
      @(posedge clk);
      #1;
      chk("sw_addr", 128'(bus.data_sram_addr), 128'h0FFC);
      chk("sw_wen", 128'(bus.data_sram_wen), 128'hF);
      chk("sw_wdata", 128'(bus.data_sram_wdata), 128'hDEAD_BEEF);

      t = '0;
      t.mult = 1'b1;
      t.rs_val = 32'h8000_0000;
      t.rt_val = 32'd2;
      tick(t, 2'b00, 1'b0);
      @(posedge clk);
      #1;
      chk("mult_hilo", 128'(bus.ex_hilo), 128'({2'b11, 64'hFFFF_FFFF_0000_0000}));

      t = '0;
      t.div = 1'b1;
      t.rs_val = -32'd7;
      t.rt_val = 32'd2;
      run_div(t, ns, hl, got);
      chk("div_stalls", 128'(ns), 128'd33);
      chk("div_hilo", 128'(hl), 128'({2'b11, 64'hFFFF_FFFF_FFFF_FFFD}));
      tick('0, 2'b00, 1'b0);
      @(posedge clk);
      #1;
      chk("div_one_shot", 128'(bus.ex_hilo), 128'h0);

      t = '0;
      t.divu = 1'b1;
      t.rs_val = 32'd5;
      t.rt_val = 32'd0;
      run_div(t, ns, hl, got);
      chk("divu0_stalls", 128'(ns), 128'd33);
      chk("divu0_hilo", 128'(hl), 128'({2'b11, 64'h0000_0005_FFFF_FFFF}));

      t = '0;
      t.div = 1'b1;
      t.rs_val = 32'd100;
      t.rt_val = -32'd7;
      tick(t, 2'b00, 1'b0);
      repeat (11) tick('0, 2'b00, 1'b0);
      tick('0, 2'b00, 1'b1);
      @(posedge clk);
      #1;
      chk("rst_mid_stall", 128'(bus.stallreq_for_ex), 128'h0);
      chk("rst_mid_hilo", 128'(bus.ex_hilo), 128'h0);
      run_div(t, ns, hl, got);
      chk("after_rst_stalls", 128'(ns), 128'd33);
      chk("after_rst_hilo", 128'(hl), 128'({2'b11, 64'h0000_0002_FFFF_FFF2}));

      for (int i = 0; i < 3000; i++) begin
         x = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         tick(rand_bus(), x, $urandom_range(0, 299) == 0);
      end
      repeat (40) tick('0, 2'b00, 1'b0);
      @(negedge clk);
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ex.md
EX -- requirements
Module: ex

Interface
REQ-001 SHALL have parameter ID_TO_EX_WD, default 162, which is the input bus width.
REQ-002 SHALL have parameter EX_TO_MEM_WD, default 73, which is the output bus width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port stall, input, 6 bits: pipeline stall vector; bit 2 = decode, bit 3 = execute; 1 = Stop.
REQ-006 SHALL have port id_to_ex_bus, input, 162 bits, MSB first: {div, divu, mult, multu, mthi, mtlo, pc[31:0], inst[31:0], alu_op[11:0], sel_src1[2:0], sel_src2[3:0], ram_en, ram_wen, rf_we, rf_waddr[4:0], sel_rf_res, rs_val[31:0], rt_val[31:0]}.
REQ-007 SHALL have port ex_to_mem_bus, output, 73 bits: {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}.
REQ-008 SHALL have port ex_rf_we, output, 1 bit: forwarding write enable.
REQ-009 SHALL have port ex_rf_waddr, output, 5 bits: forwarding destination register.
REQ-010 SHALL have port ex_ex_result, output, 32 bits: forwarding value.
REQ-011 SHALL have port is_lw, output, 1 bit: the executing instruction is a load.
REQ-012 SHALL have port ex_hilo, output, 66 bits: {hi_we, lo_we, hi[31:0], lo[31:0]}.
REQ-013 SHALL have port data_sram_en, output, 1 bit: data SRAM enable.
REQ-014 SHALL have port data_sram_wen, output, 4 bits: byte write enables.
REQ-015 SHALL have port data_sram_addr, output, 32 bits: data SRAM address.
REQ-016 SHALL have port data_sram_wdata, output, 32 bits: data SRAM write data.
REQ-017 SHALL have port stallreq_for_ex, output, 1 bit: execute stage requests a stall.

Function
REQ-018 SHALL update the pipeline register as follows, in priority order:
- rst: clear to 0.
- stall[2]=1 and stall[3]=0: load 0 (bubble).
- stall[2]=0: load id_to_ex_bus.
- otherwise: hold.
REQ-019 SHALL select src1 as rs_val if sel_src1[0], pc if sel_src1[1], {27'b0, inst[10:6]} if sel_src1[2], else 0.
REQ-020 SHALL select src2 as rt_val if sel_src2[0], sign-extended inst[15:0] if sel_src2[1], 32'd8 if sel_src2[2], zero-extended inst[15:0] if sel_src2[3], else 0.
REQ-021 SHALL decode alu_op bits [11:0] as {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}, all combinational with modulo-2^32 wrap.
REQ-022 SHALL shift src2 by src1[4:0] for the shift operations.
REQ-023 SHALL compute lui as {src2[15:0], 16'b0}.
REQ-024 SHALL compute slt and sltu as a 0/1 result.
REQ-025 SHALL output ex_result=0 when no alu_op bit is set.
REQ-026 SHALL drive ex_rf_we/ex_rf_waddr/ex_ex_result from the registered rf_we/rf_waddr and ex_result.
REQ-027 SHALL drive is_lw = sel_rf_res.
REQ-028 SHALL drive data_sram_en = ram_en, data_sram_wen = {4{ram_wen}}, data_sram_addr = ex_result, and data_sram_wdata = rt_val.
REQ-029 SHALL compute mult/multu in one cycle, a signed/unsigned 64-bit product, with ex_hilo = {1, 1, prod[63:32], prod[31:0]}.
REQ-030 SHALL make mthi give ex_hilo = {1, 0, rs_val, 0}.
REQ-031 SHALL make mtlo give ex_hilo = {0, 1, 0, rs_val}.
REQ-032 SHALL drive ex_hilo = 0 otherwise.
REQ-033 SHALL implement div/divu as an iterative restoring divider with FSM states IDLE, BUSY, DONE.
REQ-034 SHALL, in IDLE with div/divu registered: latch |rs|/|rt| (signed) or raw operands, set count=0, go to BUSY, and assert stallreq_for_ex in that same cycle.
REQ-035 SHALL, in BUSY, produce one quotient bit per cycle, increment count, and keep stallreq_for_ex=1.
REQ-036 SHALL go to DONE after count reaches 31, i.e. exactly 32 BUSY cycles.
REQ-037 SHALL, in DONE, deassert stallreq_for_ex and present ex_hilo = {1, 1, remainder, quotient} for exactly one cycle, then go to IDLE.
REQ-038 SHALL, for signed div, negate the quotient if the operand signs differ and give the remainder the dividend's sign.
REQ-039 SHALL, on a divisor of 0, produce quotient 0xFFFFFFFF and remainder = dividend, with the same 34-cycle timing.
REQ-040 SHALL keep stallreq_for_ex=0 whenever no divide is active.
REQ-041 SHALL start a new divide only from IDLE, so a held instruction never restarts.

Reset
REQ-042 SHALL, on rst, clear the pipeline register, set the FSM to IDLE, count=0, and stallreq_for_ex=0.
REQ-043 SHALL, on rst, have all outputs equal 0.
REQ-044 SHALL, when rst is asserted mid-divide, abort the divide immediately and produce no hilo write.

Verification
REQ-045 SHALL pass the test: addu with rs_val=0xFFFFFFFF, rt_val=2 -> ex_ex_result=0x00000001 and ex_rf_we=1, one cycle after load.
REQ-046 SHALL pass the test: sw with rs_val=0x1000, imm=0xFFFC, rt_val=0xDEADBEEF -> data_sram_addr=0x0FFC, data_sram_wen=4'hF, data_sram_wdata=0xDEADBEEF.
REQ-047 SHALL pass the test: div with rs_val=-7, rt_val=2 -> stallreq_for_ex high for 33 cycles, then ex_hilo = {1, 1, 0xFFFFFFFF, 0xFFFFFFFD} for one cycle.
REQ-048 SHALL pass the test: divu with rt_val=0, rs_val=5 -> lo=0xFFFFFFFF and hi=5 after 34 cycles.
REQ-049 SHALL pass the test: mult with 0x80000000 × 2 -> hi=0xFFFFFFFF, lo=0x00000000, same cycle.
REQ-050 SHALL pass the test: rst pulsed at BUSY cycle 10 -> next cycle stallreq_for_ex=0 and ex_hilo=0, and the next div completes normally.
